// File: rtl/ft232r_pkg.sv
// rtl/ft232r_pkg.sv - shared ft232r definitions: response-arbiter FSM encoding and defaults
package ft232r_pkg;

    localparam int unsigned C_N_REQ_DEF   = 4;
    localparam int unsigned C_TIMEOUT_DEF = 65535;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } rsp_state_t;

endpackage

// File: rtl/ft232r_rsp_arb_rr_arbiter.sv
// rtl/ft232r_rsp_arb_rr_arbiter.sv - round-robin selector: first active request at or after ptr
module rr_arbiter #(
    parameter int unsigned P_N  = 4,
    parameter int unsigned P_PW = 2
) (
    input  logic [P_N-1:0]  req,
    input  logic [P_PW-1:0] ptr,
    output logic [P_N-1:0]  grant,
    output logic            valid
);

    logic [P_PW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < P_N; k++) begin
            idx = P_PW'((32'(ptr) + k) % P_N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ft232r_rsp_arb.sv
// rtl/ft232r_rsp_arb.sv - multi-requester byte arbiter in front of the FT232R UART serializer
module ft232r_rsp_arb
    import ft232r_pkg::*;
#(
    parameter int unsigned P_N_REQ   = C_N_REQ_DEF,
    parameter int unsigned P_TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [P_N_REQ-1:0]   req,
    input  logic [P_N_REQ-1:0]   req_last,
    input  logic [8*P_N_REQ-1:0] req_data,
    output logic [P_N_REQ-1:0]   ack,
    output logic                 rsp_req,
    output logic [7:0]           rsp_data,
    input  logic                 rsp_ack,
    output logic [P_N_REQ-1:0]   grant,
    output logic                 err_timeout
);

    localparam int unsigned PW = $clog2(P_N_REQ);
    localparam int unsigned CW = $clog2(P_TIMEOUT + 1);

    rsp_state_t         state;
    rsp_state_t         state_nxt;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      owner_inc;
    logic [PW-1:0]      sel_idx;
    logic [7:0]         sel_byte;
    logic               sel_last;
    logic [P_N_REQ-1:0] owner_oh;
    logic [P_N_REQ-1:0] arb_req;
    logic [P_N_REQ-1:0] arb_grant;
    logic               arb_valid;
    logic               pending;
    logic               locked;
    logic               last_q;
    logic               timeout_hit;
    logic [CW-1:0]      cnt;

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    assign owner_inc   = (owner == PW'(P_N_REQ - 1)) ? '0 : owner + PW'(1);
    assign timeout_hit = (cnt == CW'(P_TIMEOUT - 1));
    // While a packet is open only its owner may compete, so its bytes stay contiguous.
    assign arb_req     = locked ? (req & owner_oh) : req;

    rr_arbiter #(
        .P_N  (P_N_REQ),
        .P_PW (PW)
    ) u_rr (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        sel_idx  = '0;
        sel_byte = '0;
        sel_last = 1'b0;
        for (int i = 0; i < P_N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_idx  = PW'(i);
                sel_byte = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rsp_req   = 1'b0;
        ack       = '0;
        grant     = '0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_nxt = ST_SEND;
                end
                if (locked) begin
                    grant = owner_oh;
                end
            end
            ST_SEND: begin
                rsp_req = 1'b1;
                grant   = owner_oh;
                if (rsp_ack || timeout_hit) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                ack   = owner_oh;
                grant = owner_oh;
                if (!req[owner]) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                grant     = owner_oh;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // pending marks the selection cycle, giving the two-cycle request-to-rsp_req latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= '0;
            ptr         <= '0;
            pending     <= 1'b0;
            locked      <= 1'b0;
            last_q      <= 1'b0;
            rsp_data    <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        cnt     <= '0;
                    end else if (arb_valid) begin
                        pending  <= 1'b1;
                        owner    <= sel_idx;
                        rsp_data <= sel_byte;
                        last_q   <= sel_last;
                    end
                end
                ST_SEND: begin
                    if (rsp_ack) begin
                        locked <= !last_q;
                        if (last_q) begin
                            ptr <= owner_inc;
                        end
                    end else if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        locked      <= 1'b0;
                        ptr         <= owner_inc;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ft232r_rsp_arb.sv
// tb/tb_ft232r_rsp_arb.sv - randomized scoreboard bench for ft232r_rsp_arb
module tb_ft232r_rsp_arb;

    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int LIMIT = 4000;

    typedef struct {
        int         owner;
        logic [7:0] data;
        bit         to;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic           rsp_req;
    logic [7:0]     rsp_data;
    logic           rsp_ack;
    logic [N-1:0]   grant;
    logic           err_timeout;

    logic       r_req  [N];
    logic       r_last [N];
    logic [7:0] r_data [N];

    logic [8:0] bq [N][$];
    logic [8:0] mq [N][$];
    exp_t       expq [$];
    int         mptr;
    int         checks;
    int         errors;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req[g]            = r_req[g];
        assign req_last[g]       = r_last[g];
        assign req_data[8*g +: 8] = r_data[g];
    end

    always #5 clk = ~clk;

    ft232r_rsp_arb #(
        .P_N_REQ   (N),
        .P_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_last    (req_last),
        .req_data    (req_data),
        .ack         (ack),
        .rsp_req     (rsp_req),
        .rsp_data    (rsp_data),
        .rsp_ack     (rsp_ack),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, LIMIT);
    endtask

    // Packet-level reference: owner is the locked requester, else the first one with bytes left from mptr.
    task automatic build(input int to_pct, input bit force_first);
        bit         lk;
        bit         first;
        int         lo;
        int         own;
        logic [8:0] b;
        exp_t       e;
        for (int i = 0; i < N; i++) mq[i] = bq[i];
        lk    = 1'b0;
        lo    = 0;
        first = force_first;
        while (1'b1) begin
            own = -1;
            if (lk) own = lo;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (own < 0 && mq[(mptr + k) % N].size() > 0) own = (mptr + k) % N;
                end
            end
            if (own < 0) break;
            b       = mq[own].pop_front();
            e.owner = own;
            e.data  = b[7:0];
            e.to    = first || ($urandom_range(0, 99) < to_pct);
            first   = 1'b0;
            expq.push_back(e);
            if (!e.to && !b[8]) begin
                lk = 1'b1;
                lo = own;
            end else begin
                lk   = 1'b0;
                mptr = (own + 1) % N;
            end
        end
    endtask

    task automatic requester(input int i);
        logic [8:0] b;
        int         w;
        while (bq[i].size() > 0) begin
            b         = bq[i].pop_front();
            r_data[i] = b[7:0];
            r_last[i] = b[8];
            r_req[i]  = 1'b1;
            w = 0;
            while (!ack[i] && w < LIMIT) begin @(negedge clk); w++; end
            if (w >= LIMIT) bound_fail("requester_ack_rise");
            r_req[i] = 1'b0;
            w = 0;
            while (ack[i] && w < LIMIT) begin @(negedge clk); w++; end
            if (w >= LIMIT) bound_fail("requester_ack_fall");
        end
    endtask

    task automatic serializer(input int n);
        exp_t e;
        int   w;
        int   h;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!rsp_req && w < LIMIT) begin @(negedge clk); w++; end
            if (w >= LIMIT) begin
                bound_fail("serializer_rsp_req");
                return;
            end
            e = expq.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("grant_send", grant, 32'd1 << e.owner);
            if (e.to) begin
                h = 0;
                while (rsp_req && h < 100) begin h++; @(negedge clk); end
                chk("timeout_len", h, TO);
                chk("err_timeout", err_timeout, 1);
                chk("timeout_ack", ack, 32'd1 << e.owner);
            end else begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                chk("send_hold", rsp_req, 1);
                rsp_ack = 1'b1;
                @(negedge clk);
                rsp_ack = 1'b0;
                chk("rsp_req_drop", rsp_req, 0);
                chk("ack_owner", ack, 32'd1 << e.owner);
            end
        end
    endtask

    task automatic run_scen(input int to_pct, input bit force_first);
        int n;
        expq.delete();
        build(to_pct, force_first);
        n = expq.size();
        fork
            requester(0);
            requester(1);
            requester(2);
            requester(3);
            serializer(n);
        join
        repeat (3) @(negedge clk);
        chk("idle_grant", grant, 0);
        chk("scoreboard_left", expq.size(), 0);
    endtask

    task automatic add_pkt(input int i, input int len);
        for (int j = 0; j < len; j++) begin
            bq[i].push_back({(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
        end
    endtask

    initial begin
        int w;
        checks  = 0;
        errors  = 0;
        mptr    = 0;
        rst_n   = 1'b0;
        rsp_ack = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_req[i]  = 1'b0;
            r_last[i] = 1'b0;
            r_data[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_rsp_req", rsp_req, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ack", ack, 0);
        chk("rst_grant", grant, 0);
        chk("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single byte with latency
        r_data[0] = 8'hA5;
        r_last[0] = 1'b1;
        r_req[0]  = 1'b1;
        @(negedge clk);
        chk("lat1_rsp_req", rsp_req, 0);
        @(negedge clk);
        chk("lat2_rsp_req", rsp_req, 1);
        chk("single_data", rsp_data, 8'hA5);
        chk("single_grant", grant, 1);
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        chk("single_rsp_drop", rsp_req, 0);
        chk("single_ack", ack, 1);
        r_req[0] = 1'b0;
        @(negedge clk);
        chk("single_ack_drop", ack, 0);
        mptr = 1;
        repeat (3) @(negedge clk);

        // reset in the middle of a byte
        r_data[2] = 8'h3C;
        r_last[2] = 1'b1;
        r_req[2]  = 1'b1;
        w = 0;
        while (!rsp_req && w < LIMIT) begin @(negedge clk); w++; end
        if (w >= LIMIT) bound_fail("reset_test_rsp_req");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_req", rsp_req, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_ack", ack, 0);
        r_req[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stray_ack", ack, 0);
            chk("stray_rsp_req", rsp_req, 0);
        end
        mptr = 0;

        // packet lock: 01,02,03 from requester 0 while 3 waits
        bq[0].push_back(9'h001);
        bq[0].push_back(9'h002);
        bq[0].push_back(9'h103);
        add_pkt(3, 1);
        run_scen(0, 1'b0);

        // contention 1 vs 2 from ptr 0, then 0 vs 3 exposes ptr=3
        add_pkt(1, 1);
        add_pkt(2, 1);
        run_scen(0, 1'b0);
        add_pkt(0, 1);
        add_pkt(3, 1);
        run_scen(0, 1'b0);

        chk("err_before_timeout", err_timeout, 0);
        add_pkt(1, 1);
        add_pkt(2, 2);
        run_scen(0, 1'b1);

        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(0, 2)) add_pkt(i, $urandom_range(1, 4));
            end
            run_scen((s >= 3) ? 15 : 0, 1'b0);
        end

        // fairness: 100 single-byte packets from all four requesters
        for (int i = 0; i < N; i++) repeat (25) add_pkt(i, 1);
        run_scen(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/ft232r_rsp_arb.md
FT232R_RSP_ARB -- requirements
Module: ft232r_rsp_arb

Interface
REQ-001 The block SHALL have parameter P_N_REQ, default 4: number of requesters (2..8).
REQ-002 The block SHALL have parameter P_TIMEOUT, default 65535: clock cycles to wait for rsp_ack before aborting a byte.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  P_N_REQ  per-requester 4-phase request; byte valid while high.
REQ-006 The block SHALL have port req_last  input  P_N_REQ  byte is the final byte of its packet; sampled with req.
REQ-007 The block SHALL have port req_data  input  8*P_N_REQ  byte i on bits [8i+7:8i]; held stable while req[i] is high.
REQ-008 The block SHALL have port ack  output  P_N_REQ  per-requester 4-phase acknowledge.
REQ-009 The block SHALL have port rsp_req  output  1  byte request toward the UART serializer; the serializer triggers on its rising edge.
REQ-010 The block SHALL have port rsp_data  output  8  byte toward the serializer; stable while rsp_req is high.
REQ-011 The block SHALL have port rsp_ack  input  1  one-cycle done pulse from the serializer.
REQ-012 The block SHALL have port grant  output  P_N_REQ  one-hot current owner; all zero when idle.
REQ-013 The block SHALL have port err_timeout  output  1  sticky; set on any timeout; cleared only by reset.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, ACK and GAP.
REQ-015 In IDLE with no packet lock, the block SHALL select a requester by round-robin over req, starting at pointer ptr, and latch its index and req_data byte.
REQ-016 In IDLE with a packet lock held, the block SHALL consider only the locked requester.
REQ-017 IDLE -> SEND SHALL occur on the cycle after selection; rsp_req SHALL be 1 and rsp_data SHALL equal the latched byte throughout SEND.
REQ-018 SEND -> ACK SHALL occur on rsp_ack=1; rsp_req SHALL drop to 0 in the same transition.
REQ-019 In ACK, ack[owner] SHALL be 1; ACK -> GAP SHALL occur when req[owner]=0, and ack SHALL then drop to 0.
REQ-020 GAP SHALL last exactly 1 cycle so that rsp_req is low for at least 2 cycles between bytes; GAP -> IDLE.
REQ-021 If the completed byte had req_last=0, the lock SHALL be held on the owner; if req_last=1, the lock SHALL release and ptr SHALL become owner+1 modulo P_N_REQ.
REQ-022 The timeout counter SHALL reset on SEND entry and increment each SEND cycle; on reaching P_TIMEOUT the block SHALL drop rsp_req, set err_timeout and go to ACK, so the requester is still released.
REQ-023 A timeout SHALL release the packet lock and advance ptr as in REQ-021.
REQ-024 An rsp_ack arriving outside SEND SHALL be ignored.
REQ-025 A requester dropping req while in SEND SHALL be ignored; the latched byte SHALL still be sent.
REQ-026 Simultaneous requests SHALL be resolved by ptr order only; no requester SHALL wait more than P_N_REQ-1 packets.
REQ-027 The grant output SHALL be one-hot of owner in SEND, ACK and GAP, hold the owner while the lock is held, and be zero otherwise.
REQ-028 Latency from req rising (idle arbiter) to rsp_req rising SHALL be 2 cycles.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force: FSM=IDLE, rsp_req=0, rsp_data=0, ack=0, grant=0, err_timeout=0, ptr=0, lock released, counter=0.
REQ-030 Reset asserted mid-byte SHALL drop rsp_req immediately; the serializer may still finish that byte, and its rsp_ack SHALL be ignored per REQ-024.

Structure
REQ-031 The FSM state encoding and the defaults of P_N_REQ and P_TIMEOUT SHALL reside in the shared ft232r definitions package.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant, valid).

Verification
REQ-033 Single byte: req[0]=1 with 0xA5 and last=1 -> rsp_req rises 2 cycles later with rsp_data=0xA5; rsp_ack -> ack[0]=1; req drop -> ack drop.
REQ-034 Contention: req[1] and req[2] both high, ptr=0, single-byte packets -> requester 1 served before 2; next ptr=3.
REQ-035 Packet lock: requester 0 sends 0x01, 0x02, 0x03 (last on 0x03) while req[3] is held high -> serializer sees 01, 02, 03, then requester 3's byte.
REQ-036 Timeout: P_TIMEOUT=16 with no rsp_ack -> rsp_req falls after 16 SEND cycles, err_timeout=1, ack[owner]=1.
REQ-037 Reset mid-SEND: rst_n low -> all outputs 0 immediately; a stray rsp_ack after reset produces no ack.
REQ-038 Fairness: all 4 requesters send continuous single-byte packets -> grant order 0, 1, 2, 3, 0, with no starvation over 100 packets.
